// File: rtl/multi_sq_gen.sv
// Multi-channel programmable square-wave generator.
// Each channel divides clk by its own divisor and emits a square wave plus a one-cycle wrap tick.
module multi_sq_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 16,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [DIV_W-1:0]  i_wr_div,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_resync,
  output logic [NUM_CH-1:0] o_sq_out,
  output logic [NUM_CH-1:0] o_tick
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] r_cnt;
    logic             r_sq;
    logic             r_tick;
    logic             w_wr;
    logic             w_wrap;
    logic [DIV_W-1:0] w_pend_nxt;
    logic [DIV_W-1:0] w_d;
    logic [DIV_W-1:0] w_hi;
    logic [DIV_W-1:0] w_cnt_nxt;

    // Out-of-range channel numbers simply match no channel, so such writes are dropped.
    assign w_wr       = i_wr_en && (i_wr_ch == CH_W'(g));
    assign w_pend_nxt = w_wr ? i_wr_div : r_pend;
    assign w_d        = (r_div < DIV_W'(2)) ? DIV_W'(2) : r_div;
    // (D+1)>>1 formed without needing an extra bit for D at full scale.
    assign w_hi       = (w_d >> 1) + DIV_W'(w_d[0]);
    assign w_wrap     = (r_cnt == w_d - DIV_W'(1));
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div  <= DIV_W'(DEFAULT_DIV);
        r_pend <= DIV_W'(DEFAULT_DIV);
        r_cnt  <= '0;
        r_sq   <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_pend <= w_pend_nxt;
        if (i_resync || !i_ch_en[g]) begin
          r_cnt  <= '0;
          r_sq   <= 1'b0;
          r_tick <= 1'b0;
          r_div  <= w_pend_nxt;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_tick <= w_wrap;
          r_sq   <= (w_cnt_nxt < w_hi);
          // Divisor only swaps at a wrap so a period is never cut short.
          if (w_wrap) r_div <= w_pend_nxt;
        end
      end
    end

    assign o_sq_out[g] = r_sq;
    assign o_tick[g]   = r_tick;
  end

endmodule

// File: tb/tb_multi_sq_gen.sv
// Self-checking bench for multi_sq_gen: directed table, hand sequences, and randomized
// traffic against a behavioural model, on a 4-channel and a 3-channel instance.
module tb_multi_sq_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [15:0] wr_div = '0;
  logic [3:0]  ch_en = '0;
  logic        resync = 1'b0;
  logic [3:0]  sq;
  logic [3:0]  tk;
  logic [2:0]  sq3;
  logic [2:0]  tk3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_sq_gen #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_div(wr_div),
    .i_ch_en(ch_en), .i_resync(resync), .o_sq_out(sq), .o_tick(tk)
  );

  multi_sq_gen #(.NUM_CH(3), .DIV_W(16), .DEFAULT_DIV(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_div(wr_div),
    .i_ch_en(ch_en[2:0]), .i_resync(resync), .o_sq_out(sq3), .o_tick(tk3)
  );

  // Reference model: per instance/channel, edges elapsed since the last wrap or phase zero.
  int m_div [2][4];
  int m_pend[2][4];
  int m_pos [2][4];
  bit m_sq  [2][4];
  bit m_tick[2][4];

  function automatic int eff_div(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 4; c++) begin
        m_div[u][c] = 2; m_pend[u][c] = 2; m_pos[u][c] = 0;
        m_sq[u][c] = 0; m_tick[u][c] = 0;
      end
  endtask

  task automatic model_step(input bit we, input int wc, input int wd, input bit [3:0] en, input bit rs);
    for (int u = 0; u < 2; u++) begin
      int nch;
      nch = (u == 0) ? 4 : 3;
      for (int c = 0; c < nch; c++) begin
        int pn;
        int d;
        pn = (we && wc == c) ? wd : m_pend[u][c];
        if (rs || !en[c]) begin
          m_pos[u][c] = 0; m_sq[u][c] = 0; m_tick[u][c] = 0; m_div[u][c] = pn;
        end else begin
          d = eff_div(m_div[u][c]);
          m_pos[u][c] = m_pos[u][c] + 1;
          m_tick[u][c] = 0;
          if (m_pos[u][c] == d) begin
            m_pos[u][c] = 0; m_tick[u][c] = 1; m_div[u][c] = pn;
          end
          m_sq[u][c] = (m_pos[u][c] < (d + 1) / 2);
        end
        m_pend[u][c] = pn;
      end
    end
  endtask

  function automatic logic [3:0] m_vec(int u, bit want_tick);
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c] = want_tick ? m_tick[u][c] : m_sq[u][c];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic we, input logic [1:0] wc, input logic [15:0] wd,
                      input logic [3:0] en, input logic rs);
    wr_en = we; wr_ch = wc; wr_div = wd; ch_en = en; resync = rs;
    @(posedge clk);
    model_step(we, int'(wc), int'(wd), en, rs);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  wc;
    logic [15:0] wd;
    logic [3:0]  en;
    logic        rs;
    logic [3:0]  e_sq;
    logic [3:0]  e_tk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [1:0] wc, logic [15:0] wd, logic [3:0] en,
                              logic rs, logic [3:0] e_sq, logic [3:0] e_tk);
    vec_t v;
    v.we = we; v.wc = wc; v.wd = wd; v.en = en; v.rs = rs; v.e_sq = e_sq; v.e_tk = e_tk;
    return v;
  endfunction

  initial begin
    int ch1_sq[10];
    int ch1_tk[10];
    int c2_sq[14];
    int c2_tk[14];
    int c0_en[9];
    int c0_sq[9];
    int c0_tk[9];
    logic [3:0] e4;
    logic [2:0] e3;

    ch1_sq = '{1,1,0,0,1,1,1,0,0,1};
    ch1_tk = '{0,0,0,0,1,0,0,0,0,1};
    tbl.push_back(mk(1'b1, 2'd1, 16'd5, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    tbl.push_back(mk(1'b0, 2'd0, 16'd0, 4'b0010, 1'b1, 4'b0000, 4'b0000));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1'b0, 2'd0, 16'd0, 4'b0010, 1'b0,
                       (ch1_sq[k] != 0) ? 4'b0010 : 4'b0000, (ch1_tk[k] != 0) ? 4'b0010 : 4'b0000));
    tbl.push_back(mk(1'b1, 2'd3, 16'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(1'b0, 2'd0, 16'd0, 4'b1000, 1'b0,
                       (k % 2 == 0) ? 4'b1000 : 4'b0000, (k % 2 == 0) ? 4'b1000 : 4'b0000));
    tbl.push_back(mk(1'b1, 2'd3, 16'd1, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(1'b0, 2'd0, 16'd0, 4'b1000, 1'b0,
                       (k % 2 == 0) ? 4'b1000 : 4'b0000, (k % 2 == 0) ? 4'b1000 : 4'b0000));

    // Reset state, all channels enabled at the default divisor.
    model_reset();
    rst_n = 1'b0; ch_en = 4'b1111;
    #12;
    chk("rst_sq", sq, 4'b0000);
    chk("rst_tick", tk, 4'b0000);
    chk("rst_sq3", sq3, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 2'd0, 16'd0, 4'b1111, 1'b0);
      e4 = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      e3 = (k % 2 == 0) ? 3'b111 : 3'b000;
      chk("def_sq", sq, e4);
      chk("def_tick", tk, e4);
      chk("def_sq3", sq3, e3);
      chk("def_tick3", tk3, e3);
    end

    // Channel number beyond NUM_CH on the 3-channel instance must be dropped.
    step(1'b1, 2'd3, 16'd5, 4'b0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 2'd0, 16'd0, 4'b0111, 1'b0);
      e3 = (k % 2 == 0) ? 3'b111 : 3'b000;
      chk("oor_sq3", sq3, e3);
      chk("oor_tick3", tk3, e3);
      chk("oor_sq", sq, {1'b0, e3});
    end

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].wc, tbl[i].wd, tbl[i].en, tbl[i].rs);
      chk($sformatf("tbl%0d_sq", i), sq, tbl[i].e_sq);
      chk($sformatf("tbl%0d_tick", i), tk, tbl[i].e_tk);
    end

    // Ch2 at D=4, write 6 while cnt==1; new divisor only from the next wrap.
    c2_sq = '{1,0,0,1,1,0,0,1,1,1,0,0,0,1};
    c2_tk = '{0,0,0,1,0,0,0,1,0,0,0,0,0,1};
    step(1'b1, 2'd2, 16'd4, 4'b0000, 1'b0);
    for (int k = 0; k < 14; k++) begin
      if (k == 5) step(1'b1, 2'd2, 16'd6, 4'b0100, 1'b0);
      else        step(1'b0, 2'd0, 16'd0, 4'b0100, 1'b0);
      chk($sformatf("ch2_sq_e%0d", k + 1), sq, (c2_sq[k] != 0) ? 4'b0100 : 4'b0000);
      chk($sformatf("ch2_tick_e%0d", k + 1), tk, (c2_tk[k] != 0) ? 4'b0100 : 4'b0000);
    end

    // Ch0 at D=3: drop enable mid-high, then re-enable from phase zero.
    c0_en = '{1,1,1,1,0,0,1,1,1};
    c0_sq = '{1,0,1,1,0,0,1,0,1};
    c0_tk = '{0,0,1,0,0,0,0,0,1};
    step(1'b1, 2'd0, 16'd3, 4'b0000, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 2'd0, 16'd0, (c0_en[k] != 0) ? 4'b0001 : 4'b0000, 1'b0);
      chk($sformatf("ch0_sq_e%0d", k + 1), sq, (c0_sq[k] != 0) ? 4'b0001 : 4'b0000);
      chk($sformatf("ch0_tick_e%0d", k + 1), tk, (c0_tk[k] != 0) ? 4'b0001 : 4'b0000);
    end

    // Randomized traffic against the model on both instances.
    for (int k = 0; k < 3000; k++) begin
      logic        we;
      logic [1:0]  wc;
      logic [15:0] wd;
      logic [3:0]  en;
      logic        rs;
      we = ($urandom_range(0, 99) < 15);
      wc = 2'($urandom_range(0, 3));
      wd = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 30)) : 16'($urandom_range(0, 9));
      for (int c = 0; c < 4; c++) en[c] = ($urandom_range(0, 99) < 93);
      rs = ($urandom_range(0, 99) < 2);
      step(we, wc, wd, en, rs);
      chk("rand_sq", sq, m_vec(0, 1'b0));
      chk("rand_tick", tk, m_vec(0, 1'b1));
      chk("rand_sq3", sq3, m_vec(1, 1'b0) & 4'b0111);
      chk("rand_tick3", tk3, m_vec(1, 1'b1) & 4'b0111);
    end

    // Asynchronous reset between edges while outputs are high.
    for (int c = 0; c < 4; c++) step(1'b1, 2'(c), 16'd2, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 16'd7, 4'b1111, 1'b0);
    chk("pre_rst_sq_e1", sq, 4'b0000);
    step(1'b0, 2'd0, 16'd0, 4'b1111, 1'b0);
    chk("pre_rst_sq_e2", sq, 4'b1111);
    chk("pre_rst_tick_e2", tk, 4'b1111);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_sq", sq, 4'b0000);
    chk("async_rst_tick", tk, 4'b0000);
    chk("async_rst_sq3", sq3, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 2'd0, 16'd0, 4'b1111, 1'b0);
      e4 = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      chk("post_rst_sq", sq, e4);
      chk("post_rst_tick", tk, e4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
